pulse_period_checker: RTL and testbench
=======================================

// Module: pulse_period_checker
// PURPOSE
// Receive-side partner of the divide-by-N pulse generators. Watches a one-cycle
// pulse stream (e.g. a divide-by-3 'y') and checks that it repeats every N clocks.
// A hunt/acquire/lock FSM with a flywheel counter gives a lock indication,
// per-event error strobes and a saturating error count for status logic.
// PARAMETERS
// N          3  expected pulse period in clocks (N >= 2)
// LOCK_COUNT 4  consecutive on-time pulses in ACQ needed to enter LOCKED (>= 1)
// MISS_LIMIT 2  consecutive errors in LOCKED that force a return to HUNT (>= 1)
// ERR_W      8  width of err_count
// PORTS
// clk        in   1      single clock, all logic on posedge
// reset      in   1      synchronous, active-low reset (0 = reset, sampled on posedge clk)
// pulse_in   in   1      pulse stream under test, synchronous to clk
// locked     out  1      1 while FSM is in LOCKED
// err_early  out  1      1-cycle strobe: pulse arrived before period N (LOCKED only)
// err_missed out  1      1-cycle strobe: no pulse at period N (LOCKED only)
// err_count  out  ERR_W  errors seen in LOCKED, saturates at 2**ERR_W-1
// state_o    out  2      FSM state: 0 HUNT, 1 ACQ, 2 LOCKED
// BEHAVIOUR
// - All outputs registered. Each output shows the result of the pulse_in sample
//   taken on the same posedge, visible right after that edge.
// - Reset (reset==0 at posedge): state=HUNT, cnt=0, good=0, miss=0. locked,
//   err_early, err_missed, err_count and state_o all 0. Reset wins over every
//   other event, including mid-LOCKED. err_count is cleared only by reset.
// - cnt (width $clog2(N)) counts clocks since the last real or flywheel pulse.
//   "on-time" = pulse_in && cnt==N-1.
//   "early"   = pulse_in && cnt<N-1.
//   "missed"  = !pulse_in && cnt==N-1.
//   On any pulse or missed event, cnt<=0. Otherwise cnt<=cnt+1.
// - HUNT: cnt held at 0. pulse_in=1 -> ACQ with cnt=0, good=0.
// - ACQ: on-time -> good++. When good reaches LOCK_COUNT -> LOCKED, miss=0.
//   Early -> good=0, resync cnt=0, stay in ACQ. Missed -> HUNT, good=0.
//   No error strobes or counting in ACQ.
// - LOCKED: on-time -> miss=0.
//   Early -> err_early=1, miss++, cnt resyncs to the early pulse.
//   Missed -> err_missed=1, miss++, flywheel: cnt restarts as if a pulse occurred.
//   Each error increments err_count (saturating).
//   When miss reaches MISS_LIMIT -> HUNT; locked drops at that same edge.
// - err_early and err_missed are mutually exclusive and high for exactly one
//   cycle per event.
// - Illegal state encoding (3) -> HUNT on the next edge.
// - A pulse_in held high every cycle is a run of early events
//   (LOCKED: errors, then HUNT after MISS_LIMIT).
// TESTING (N=3, LOCK_COUNT=4, MISS_LIMIT=2, ERR_W=8 unless noted)
// 1 reset=0 for 2 clks, pulse_in=1 -> all outputs 0, state_o=0. On release, first pulse -> state_o=1.
// 2 Clean period-3 stream -> ACQ at pulse 1, locked=1 at edge sampling pulse 5, no error strobes.
// 3 Locked, drop one pulse -> err_missed=1 for 1 clk at expected slot, err_count=1,
//   locked stays 1; next pulse 3 clks later is on-time.
// 4 Locked, drop two consecutive pulses -> 2nd slot: err_missed=1, err_count=2,
//   locked=0, state_o=0.
// 5 Locked, pulse 2 clks after previous -> err_early=1, err_count+1; pulses every 3 from
//   the early one are on-time with no further errors.
// 6 ERR_W=2, alternate early/on-time pulses in LOCKED x5 -> err_count stops at 3.
//   reset=0 mid-LOCKED -> next edge clears everything to 0.

Source files
------------

// File: rtl/pulse_period_checker.sv
// Period checker for one-cycle pulse streams: hunt/acquire/lock with flywheel.
// Reports lock, per-event error strobes and a saturating error count.
module pulse_period_checker #(
  parameter int N          = 3,
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic             locked,
  output logic             err_early,
  output logic             err_missed,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_o
);

  localparam int CW = $clog2(N);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [GW-1:0] G_TOP = GW'(LOCK_COUNT);
  localparam logic [MW-1:0] M_TOP = MW'(MISS_LIMIT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [GW-1:0]    r_good;
  logic [MW-1:0]    r_miss;
  logic             r_locked;
  logic             r_err_early;
  logic             r_err_missed;
  logic [ERR_W-1:0] r_err_count;

  logic             w_last;
  logic             w_on;
  logic             w_early;
  logic             w_missed;
  logic [GW-1:0]    w_good_inc;
  logic [MW-1:0]    w_miss_inc;
  logic [ERR_W-1:0] w_err_sat;

  assign w_last     = (r_cnt == LAST);
  assign w_on       = pulse_in && w_last;
  assign w_early    = pulse_in && (r_cnt < LAST);
  assign w_missed   = !pulse_in && w_last;
  assign w_good_inc = r_good + GW'(1);
  assign w_miss_inc = r_miss + MW'(1);
  assign w_err_sat  = (r_err_count == '1) ? r_err_count
                                          : r_err_count + ERR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= HUNT;
      r_cnt        <= '0;
      r_good       <= '0;
      r_miss       <= '0;
      r_locked     <= 1'b0;
      r_err_early  <= 1'b0;
      r_err_missed <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_err_early  <= 1'b0;
      r_err_missed <= 1'b0;
      case (r_state)
        HUNT: begin
          r_cnt <= '0;
          if (pulse_in) begin
            r_state <= ACQ;
            r_good  <= '0;
          end
        end
        ACQ: begin
          if (w_on) begin
            r_cnt  <= '0;
            r_good <= w_good_inc;
            if (w_good_inc == G_TOP) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
              r_miss   <= '0;
            end
          end else if (w_early) begin
            r_cnt  <= '0;
            r_good <= '0;
          end else if (w_missed) begin
            r_state <= HUNT;
            r_cnt   <= '0;
            r_good  <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        LOCKED: begin
          if (w_on) begin
            r_cnt  <= '0;
            r_miss <= '0;
          end else if (w_early || w_missed) begin
            // a missed slot flywheels: cnt restarts as if the pulse came
            r_cnt        <= '0;
            r_err_early  <= w_early;
            r_err_missed <= w_missed;
            r_err_count  <= w_err_sat;
            r_miss       <= w_miss_inc;
            if (w_miss_inc == M_TOP) begin
              r_state  <= HUNT;
              r_locked <= 1'b0;
              r_miss   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state  <= HUNT;
          r_cnt    <= '0;
          r_good   <= '0;
          r_miss   <= '0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign locked     = r_locked;
  assign err_early  = r_err_early;
  assign err_missed = r_err_missed;
  assign err_count  = r_err_count;
  assign state_o    = r_state;

endmodule

// File: tb/tb_pulse_period_checker.sv
// Vector + scoreboard bench for pulse_period_checker (N=3).
// Drives an ERR_W=8 and an ERR_W=2 instance with the same stream.
module tb_pulse_period_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pulse_in = 1'b0;
  logic       lk0, ee0, em0;
  logic [7:0] ec0;
  logic [1:0] st0;
  logic       lk1, ee1, em1;
  logic [1:0] ec1;
  logic [1:0] st1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pulse_period_checker #(.N(3), .LOCK_COUNT(4), .MISS_LIMIT(2), .ERR_W(8)) u0 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .locked(lk0), .err_early(ee0), .err_missed(em0),
    .err_count(ec0), .state_o(st0)
  );

  pulse_period_checker #(.N(3), .LOCK_COUNT(4), .MISS_LIMIT(2), .ERR_W(2)) u1 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .locked(lk1), .err_early(ee1), .err_missed(em1),
    .err_count(ec1), .state_o(st1)
  );

  typedef struct {
    logic       rst_n;
    logic       p;
    logic       lk;
    logic       ee;
    logic       em;
    logic [7:0] ec;
    logic [1:0] st;
  } vec_t;

  vec_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic p, input logic lk,
                      input logic ee, input logic em,
                      input logic [7:0] ec, input logic [1:0] st);
    vec_t v;
    vec_t e;
    int   ec_sat;
    @(negedge clk);
    v.rst_n = r; v.p = p; v.lk = lk; v.ee = ee;
    v.em = em; v.ec = ec; v.st = st;
    reset    = r;
    pulse_in = p;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      ec_sat = (e.ec > 8'd3) ? 3 : int'(e.ec);
      chk("locked",       lk0, e.lk);
      chk("err_early",    ee0, e.ee);
      chk("err_missed",   em0, e.em);
      chk("err_count",    ec0, e.ec);
      chk("state_o",      st0, e.st);
      chk("w2_locked",    lk1, e.lk);
      chk("w2_err_early", ee1, e.ee);
      chk("w2_err_missed",em1, e.em);
      chk("w2_err_count", ec1, ec_sat);
      chk("w2_state_o",   st1, e.st);
    end
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic p, input logic lk,
                              input logic ee, input logic em,
                              input logic [7:0] ec, input logic [1:0] st);
    vec_t v;
    v.rst_n = r; v.p = p; v.lk = lk; v.ee = ee;
    v.em = em; v.ec = ec; v.st = st;
    return v;
  endfunction

  // lock from ACQ with cnt=0: four on-time pulses, holding err count ec
  task automatic lock_up(input logic [7:0] ec);
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 0, 0, 0, ec, 2'd1);
      step(1, 0, 0, 0, 0, ec, 2'd1);
      step(1, 1, k == 4, 0, 0, ec, (k == 4) ? 2'd2 : 2'd1);
    end
  endtask

  initial begin
    // reset held with pulse high, then release
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1));
    // clean period-3 stream, locks at pulse 5
    for (int k = 2; k <= 5; k++) begin
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, k == 5, 0, 0, 0, (k == 5) ? 2'd2 : 2'd1));
    end
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 2));
    // single dropped pulse, then on-time
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 1, 0, 1, 1, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 2));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 2));
    // early pulse 2 clks after previous, then resynced stream
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 2));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 2, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 2, 2));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 2, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 2, 2));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, 2));
    // two consecutive drops -> HUNT
    tbl.push_back(mk(1, 0, 1, 0, 0, 2, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 2, 2));
    tbl.push_back(mk(1, 0, 1, 0, 1, 3, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 3, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 3, 2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 4, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4, 0));
    // held-high in ACQ stays ACQ; then a missed slot drops to HUNT
    tbl.push_back(mk(1, 1, 0, 0, 0, 4, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 4, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 4, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].p, tbl[i].lk, tbl[i].ee,
           tbl[i].em, tbl[i].ec, tbl[i].st);
    end

    // fresh reset, relock, alternate early/on-time five times
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1);
    lock_up(0);
    for (int k = 1; k <= 5; k++) begin
      step(1, 0, 1, 0, 0, 8'(k - 1), 2'd2);
      step(1, 1, 1, 1, 0, 8'(k), 2'd2);
      step(1, 0, 1, 0, 0, 8'(k), 2'd2);
      step(1, 0, 1, 0, 0, 8'(k), 2'd2);
      step(1, 1, 1, 0, 0, 8'(k), 2'd2);
    end

    // pulse held high while locked: two early errors then HUNT
    step(1, 1, 1, 1, 0, 6, 2);
    step(1, 1, 0, 1, 0, 7, 0);
    step(1, 1, 0, 0, 0, 7, 1);

    // relock, then reset mid-LOCKED clears everything
    lock_up(7);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
